// File: rtl/otfs_sym_fifo_reader.sv
// Drains the 4QAM symbol FIFO into one M x N OTFS delay-Doppler frame on a valid/ready stream.
// Define OTFS_QAM_MAP_EN to add the registered +/-AMP I/Q mapper outputs m_i/m_q.
module otfs_sym_fifo_reader #(
  parameter int SYM_W = 2,
  parameter int M     = 16,
  parameter int N     = 16,
  parameter int IQ_W  = 16,
  parameter int AMP   = 23170
) (
  input  logic                        clk,
  input  logic                        srst,
  input  logic                        frame_en,
  output logic                        fifo_rd_en,
  input  logic [SYM_W-1:0]            fifo_dout,
  input  logic                        fifo_empty,
  input  logic                        fifo_valid,
  input  logic                        fifo_underflow,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [SYM_W-1:0]            m_sym,
`ifdef OTFS_QAM_MAP_EN
  output logic signed [IQ_W-1:0]      m_i,
  output logic signed [IQ_W-1:0]      m_q,
`endif
  output logic [$clog2(M)-1:0]        m_row,
  output logic [$clog2(N)-1:0]        m_col,
  output logic                        m_sof,
  output logic                        m_eof,
  output logic                        busy,
  output logic                        frame_done,
  output logic                        err_underflow
);

  localparam int FRAME = M * N;
  localparam int CW    = $clog2(FRAME + 1);
  localparam int RW    = $clog2(M);
  localparam int NW    = $clog2(N);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      issued;
  logic               outstanding;
  logic [SYM_W-1:0]   buf_sym [2];
  logic               wr_ptr, rd_ptr;
  logic [1:0]         occ;
  logic [RW-1:0]      row;
  logic [NW-1:0]      col;
  logic               pop, wr, uf_hit, last, start;

`ifdef OTFS_QAM_MAP_EN
  localparam logic signed [IQ_W-1:0] AMP_P = IQ_W'(AMP);
  localparam logic signed [IQ_W-1:0] AMP_N = -AMP_P;
  logic signed [IQ_W-1:0] buf_i [2];
  logic signed [IQ_W-1:0] buf_q [2];
`endif

  assign m_valid = (occ != 2'd0);
  assign pop     = m_valid & m_ready;
  // A read that underflowed returns nothing and is re-issued later.
  assign wr      = fifo_valid & outstanding & ~fifo_underflow;
  assign uf_hit  = fifo_underflow & outstanding;
  assign last    = (row == RW'(M - 1)) && (col == NW'(N - 1));
  assign start   = (state == IDLE) & frame_en;

  // Never let buffered plus in-flight symbols exceed the two skid entries.
  always_comb begin
    fifo_rd_en = 1'b0;
    if (!srst && state == RUN && !fifo_empty && issued < CW'(FRAME) &&
        (({1'b0, occ} + 3'(outstanding)) < (3'd2 + 3'(pop))))
      fifo_rd_en = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (frame_en) state_nxt = RUN;
      RUN:     if (pop && last) state_nxt = IDLE;
               else if (issued == CW'(FRAME)) state_nxt = DRAIN;
      DRAIN:   if (pop && last) state_nxt = IDLE;
               else if (issued != CW'(FRAME)) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state         <= IDLE;
      issued        <= '0;
      outstanding   <= 1'b0;
      buf_sym[0]    <= '0;
      buf_sym[1]    <= '0;
      wr_ptr        <= 1'b0;
      rd_ptr        <= 1'b0;
      occ           <= 2'd0;
      row           <= '0;
      col           <= '0;
      frame_done    <= 1'b0;
      err_underflow <= 1'b0;
`ifdef OTFS_QAM_MAP_EN
      buf_i[0]      <= '0;
      buf_i[1]      <= '0;
      buf_q[0]      <= '0;
      buf_q[1]      <= '0;
`endif
    end else begin
      state       <= state_nxt;
      outstanding <= fifo_rd_en;
      frame_done  <= (state != IDLE) & pop & last;
      if (fifo_underflow)
        err_underflow <= 1'b1;
      if (start) begin
        issued <= '0;
        row    <= '0;
        col    <= '0;
      end else begin
        issued <= issued + CW'(fifo_rd_en) - CW'(uf_hit);
        // Delay index is the fast one; Doppler advances on each delay wrap.
        if (pop) begin
          row <= (row == RW'(M - 1)) ? '0 : row + RW'(1);
          if (row == RW'(M - 1))
            col <= (col == NW'(N - 1)) ? '0 : col + NW'(1);
        end
      end
      if (wr) begin
        buf_sym[wr_ptr] <= fifo_dout;
`ifdef OTFS_QAM_MAP_EN
        buf_i[wr_ptr]   <= fifo_dout[1] ? AMP_N : AMP_P;
        buf_q[wr_ptr]   <= fifo_dout[0] ? AMP_N : AMP_P;
`endif
        wr_ptr          <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      occ <= occ + 2'(wr) - 2'(pop);
    end
  end

  assign m_sym = buf_sym[rd_ptr];
`ifdef OTFS_QAM_MAP_EN
  assign m_i   = buf_i[rd_ptr];
  assign m_q   = buf_q[rd_ptr];
`endif
  assign m_row = row;
  assign m_col = col;
  assign m_sof = m_valid & (row == '0) & (col == '0);
  assign m_eof = m_valid & last;
  assign busy  = (state != IDLE);

endmodule

// File: tb/tb_otfs_sym_fifo_reader.sv
// Randomized bench for otfs_sym_fifo_reader (M=4, N=2) with a queue-based FIFO model and stream reference.
// Mapper outputs are checked when OTFS_QAM_MAP_EN is defined.
module tb_otfs_sym_fifo_reader;

  localparam int M  = 4;
  localparam int N  = 2;
  localparam int MN = M * N;

  logic        clk, srst, frame_en, fifo_rd_en, fifo_empty, fifo_valid, fifo_underflow;
  logic        m_valid, m_ready, m_sof, m_eof, busy, frame_done, err_underflow;
  logic [1:0]  fifo_dout, m_sym, m_row;
  logic [0:0]  m_col;
`ifdef OTFS_QAM_MAP_EN
  logic signed [15:0] m_i, m_q;
`endif

  otfs_sym_fifo_reader #(.SYM_W(2), .M(M), .N(N), .IQ_W(16), .AMP(23170)) dut (
    .clk(clk), .srst(srst), .frame_en(frame_en), .fifo_rd_en(fifo_rd_en),
    .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_valid(fifo_valid),
    .fifo_underflow(fifo_underflow), .m_valid(m_valid), .m_ready(m_ready), .m_sym(m_sym),
`ifdef OTFS_QAM_MAP_EN
    .m_i(m_i), .m_q(m_q),
`endif
    .m_row(m_row), .m_col(m_col), .m_sof(m_sof), .m_eof(m_eof), .busy(busy),
    .frame_done(frame_done), .err_underflow(err_underflow));

  int          n_checks, n_fail;
  logic [1:0]  fmem [0:1023];
  int          wp, rp;
  bit          uf_req, uf_taken;
  int          deliv_q[$];
  int          k, beats, inflight, exp_sym;
  bit          err_exp, done_due, prev_stall, run_chk;
  logic [31:0] prev_vec, cur_vec;
  int          got_sym [64];

  assign cur_vec    = {24'd0, m_valid, m_sym, m_row, m_col, m_sof, m_eof};
  assign fifo_empty = (rp == wp);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pushSym(input int v);
    fmem[wp] = 2'(v);
    wp++;
  endtask

  function automatic logic pickReady(input int mode, input int cyc);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (cyc % 2 == 0);
    return 1'($urandom_range(0, 1));
  endfunction

  // Standard-mode FIFO: data and valid appear the cycle after the read strobe.
  always @(posedge clk) begin
    fifo_valid     <= 1'b0;
    fifo_underflow <= 1'b0;
    if (fifo_rd_en) begin
      if (uf_req && !uf_taken) begin
        fifo_underflow <= 1'b1;
        uf_taken       <= 1'b1;
      end else if (rp < wp) begin
        fifo_dout  <= fmem[rp];
        fifo_valid <= 1'b1;
        rp         <= rp + 1;
      end else begin
        fifo_underflow <= 1'b1;
      end
    end
  end

  // Reference: the output stream is the FIFO delivery stream, indexed k = n*M + m.
  always @(negedge clk) begin
    if (srst) begin
      checkOutput("rd_en_in_srst", 32'(fifo_rd_en), 0);
      deliv_q.delete();
      k = 0; inflight = 0; err_exp = 0; done_due = 0; prev_stall = 0;
    end else if (run_chk) begin
      checkOutput("frame_done", 32'(frame_done), 32'(done_due));
      if (done_due) checkOutput("busy_after_done", 32'(busy), 0);
      checkOutput("err_underflow", 32'(err_underflow), 32'(err_exp));
      if (prev_stall) checkOutput("stall_stable", cur_vec, prev_vec);
      done_due = 0;
      if (m_valid) begin
        checkOutput("busy_while_valid", 32'(busy), 1);
        if (m_ready) begin
          if (deliv_q.size() == 0) begin
            checkOutput("beat_has_data", 0, 1);
            exp_sym = 0;
          end else begin
            exp_sym = deliv_q.pop_front();
          end
          checkOutput("m_sym", 32'(m_sym), 32'(exp_sym));
          checkOutput("m_row", 32'(m_row), 32'(k % M));
          checkOutput("m_col", 32'(m_col), 32'(k / M));
          checkOutput("m_sof", 32'(m_sof), 32'(k == 0));
          checkOutput("m_eof", 32'(m_eof), 32'(k == MN - 1));
`ifdef OTFS_QAM_MAP_EN
          checkOutput("m_i", 32'(m_i), (exp_sym & 2) ? -23170 : 23170);
          checkOutput("m_q", 32'(m_q), (exp_sym & 1) ? -23170 : 23170);
`endif
          if (beats < 64) got_sym[beats] = int'(m_sym);
          beats++;
          done_due = (k == MN - 1);
          k = (k + 1) % MN;
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_vec   = cur_vec;
      inflight   = inflight + int'(fifo_rd_en) - int'(m_valid && m_ready) - int'(fifo_underflow);
      checkOutput("inflight_le2", 32'(inflight <= 2), 1);
      if (fifo_underflow) err_exp = 1;
      if (fifo_valid && !fifo_underflow) deliv_q.push_back(int'(fifo_dout));
    end
  end

  task automatic applyStimulus(input int mode, input int n_pre, input int n_late, input int late_at,
                               input bit lit, input bit gap_chk, input int uf_at, input int rst_beat);
    bit done;
    int cyc;
    for (int i = 0; i < n_pre; i++) pushSym(lit ? i % 4 : $urandom_range(0, 3));
    beats    = 0;
    done     = 0;
    frame_en = 1'b1;
    m_ready  = pickReady(mode, 0);
    for (cyc = 0; cyc < 400 && !done; cyc++) begin
      @(posedge clk); #1;
      frame_en = 1'b0;
      m_ready  = pickReady(mode, cyc + 1);
      if (lit && cyc == 0) begin
        checkOutput("lat_rd_en_T1", 32'(fifo_rd_en), 1);
        checkOutput("lat_valid_T1", 32'(m_valid), 0);
      end
      if (lit && cyc == 1) checkOutput("lat_valid_T2", 32'(m_valid), 0);
      if (lit && cyc == 2) begin
        checkOutput("lat_valid_T3", 32'(m_valid), 1);
        checkOutput("first_sof", 32'(m_sof), 1);
        checkOutput("first_sym", 32'(m_sym), 0);
      end
      if (gap_chk && cyc == late_at - 2) begin
        checkOutput("gap_valid", 32'(m_valid), 0);
        checkOutput("gap_beats", 32'(beats), 3);
        checkOutput("gap_row", 32'(m_row), 3);
        checkOutput("gap_col", 32'(m_col), 0);
      end
      if (cyc == late_at)
        for (int i = 0; i < n_late; i++) pushSym($urandom_range(0, 3));
      if (cyc == uf_at) uf_req = 1'b1;
      if (rst_beat >= 0 && beats == rst_beat) begin
        srst = 1'b1;
        @(posedge clk); #1;
        srst = 1'b0;
        checkOutput("rst_m_valid", 32'(m_valid), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_row", 32'(m_row), 0);
        checkOutput("rst_col", 32'(m_col), 0);
        return;
      end
      if (frame_done) begin
        done = 1;
        if (lit) checkOutput("done_cycle", 32'(cyc), 10);
      end
    end
    if (!done) checkOutput("frame_timeout", 0, 1);
    else checkOutput("beat_count", 32'(beats), MN);
  endtask

  initial begin
    n_checks = 0; n_fail = 0; run_chk = 0;
    srst = 1'b1; frame_en = 1'b0; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_valid", 32'(m_valid), 0);
    checkOutput("reset_busy", 32'(busy), 0);
    checkOutput("reset_done", 32'(frame_done), 0);
    checkOutput("reset_err", 32'(err_underflow), 0);
    checkOutput("reset_sof_eof", {30'd0, m_sof, m_eof}, 0);
    checkOutput("reset_idx", {29'd0, m_row, m_col}, 0);
    checkOutput("reset_sym", 32'(m_sym), 0);
    srst = 1'b0;
    run_chk = 1;
    @(posedge clk); #1;

    applyStimulus(0, 8, 0, -1, 1, 0, -1, -1);
    for (int i = 0; i < MN; i++) checkOutput("t1_sym_seq", 32'(got_sym[i]), 32'(i % 4));
    applyStimulus(1, 8, 0, -1, 0, 0, -1, -1);
    applyStimulus(0, 3, 5, 10, 0, 1, -1, -1);
    applyStimulus(0, 8, 0, -1, 0, 0, -1, 3);
    applyStimulus(2, 8, 0, -1, 0, 0, -1, -1);
    applyStimulus(0, 8, 0, -1, 0, 0, 3, -1);
    checkOutput("err_sticky", 32'(err_underflow), 1);
    for (int f = 0; f < 5; f++) begin
      int n;
      n = $urandom_range(0, 8);
      applyStimulus(2, n, 10 - n, $urandom_range(2, 15), 0, 0, -1, -1);
    end
    checkOutput("err_still_set", 32'(err_underflow), 1);

    srst = 1'b1;
    @(posedge clk); #1;
    srst = 1'b0;
    checkOutput("final_err_cleared", 32'(err_underflow), 0);
    checkOutput("final_valid", 32'(m_valid), 0);
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/otfs_sym_fifo_reader.md
Name: otfs_sym_fifo_reader

Overview:
- Drains the 2-bit 4QAM symbol FIFO (Xilinx fifo_generator, standard read mode, srst) from the read side.
- Assembles symbols into one OTFS delay-Doppler frame of M x N symbols.
- Presents the frame downstream on a valid/ready stream with frame markers and grid indices.
- Absorbs the FIFO's 1-cycle read latency and downstream backpressure with a 2-entry skid buffer.

Parameters:
- SYM_W, 2: symbol width (bits per 4QAM symbol).
- M, 16: delay bins; inner (fast) index.
- N, 16: Doppler bins; outer (slow) index.
- IQ_W, 16: signed I/Q width; used only with the mapper.
- AMP, 23170: 1/sqrt(2) in Q1.15; mapper magnitude.

Ports:
- clk  in  1  system clock
- srst  in  1  synchronous active-high reset
- frame_en  in  1  start request; sampled in IDLE
- fifo_rd_en  out  1  FIFO read strobe
- fifo_dout  in  SYM_W  FIFO read data; valid the cycle after fifo_rd_en
- fifo_empty  in  1  FIFO empty flag
- fifo_valid  in  1  FIFO read-data valid
- fifo_underflow  in  1  FIFO underflow flag
- m_valid  out  1  output symbol valid
- m_ready  in  1  downstream ready
- m_sym  out  SYM_W  output symbol
- m_i  out  IQ_W  mapped I component (QAM_MAP_EN only)
- m_q  out  IQ_W  mapped Q component (QAM_MAP_EN only)
- m_row  out  clog2(M)  delay index m
- m_col  out  clog2(N)  Doppler index n
- m_sof  out  1  first symbol of frame (k=0)
- m_eof  out  1  last symbol of frame (k=M*N-1)
- busy  out  1  high when not in IDLE
- frame_done  out  1  one-cycle pulse at frame end
- err_underflow  out  1  sticky error flag

Behaviour:
- Reset: with srst=1, all outputs are 0 at the next edge; FSM goes to IDLE; skid buffer, counters and outstanding-read tracker cleared. fifo_rd_en is forced to 0 in any cycle where srst=1. Reset mid-frame discards the partial frame; there is no resume.
- FSM IDLE -> RUN: frame_en=1 in IDLE; issue and emit counters cleared.
- FSM RUN -> DRAIN: issue count reaches M*N; fifo_rd_en stops.
- FSM DRAIN -> IDLE: handshake (m_valid & m_ready) of the m_eof beat; frame_done pulses in the following cycle.
- Back-to-back frames: if frame_en is still high in IDLE, RUN is re-entered the next cycle.
- Read issue rule: fifo_rd_en = (state==RUN) & !fifo_empty & (issued < M*N) & (occ + outstanding - pop < 2).
  - pop = m_valid & m_ready in the current cycle.
  - outstanding is 1 for the cycle after fifo_rd_en.
- Buffer write: fifo_valid=1 writes fifo_dout into the skid buffer (depth 2, FIFO order).
  - fifo_valid with no outstanding read is ignored.
  - Buffer overflow is impossible by the issue rule.
- Output: m_valid = occ != 0. m_sym, m_row, m_col, m_sof, m_eof, m_i and m_q all come from the head entry and are stable while m_valid & !m_ready.
- Index order: k = n*M + m.
  - m_row increments every pop and wraps M-1 -> 0.
  - On each wrap, m_col increments.
  - Both reset to 0 at frame start.
- Latency: frame_en at cycle T with FIFO non-empty gives fifo_rd_en at T+1, fifo_valid at T+2, m_valid at T+3.
- Throughput: sustained 1 symbol/clk when the FIFO is non-empty and m_ready=1.
- FIFO empty mid-frame: no issue; m_valid falls once the buffer drains; indices hold; resumes seamlessly when data returns.
- err_underflow: set when fifo_underflow=1; that read is not counted (issued decremented); the flag clears only on srst.
- frame_en outside IDLE is ignored.

Optional Feature:
- Macro: OTFS_QAM_MAP_EN.
- When defined: m_i/m_q are registered with the buffer entry (no added latency).
  - m_i = sym[1] ? -AMP : +AMP
  - m_q = sym[0] ? -AMP : +AMP
- When undefined: the m_i/m_q ports are absent and the block outputs only m_sym.

Test Plan:
1. M=4, N=2; FIFO preloaded 0,1,2,3,0,1,2,3; m_ready=1; frame_en pulse.
   -> 8 consecutive beats, m_sym 0..3,0..3, m_row 0..3,0..3, m_col 0x4 then 1x4, m_sof on beat 0, m_eof on beat 7, frame_done 1 cycle after beat 7, busy then 0.
2. Same frame; m_ready pattern 1,0,1,0,...
   -> identical symbol sequence with no loss or duplicate; outstanding+occ never exceeds 2; outputs stable while stalled.
3. FIFO holds 3 symbols at start; 5 more written 10 cycles later.
   -> m_valid drops after beat 2; beats 3..7 resume with m_row=3, m_col=0 continuing; m_eof correct.
4. srst=1 for 1 cycle after beat 2 handshake.
   -> next cycle m_valid=0, busy=0, indices 0; new frame_en -> m_sof with m_row=0, m_col=0.
5. fifo_underflow forced high 1 cycle during RUN.
   -> err_underflow=1 and stays set; frame still emits exactly M*N beats.
6. With OTFS_QAM_MAP_EN:
   - sym 00 -> (+23170, +23170)
   - sym 01 -> (+23170, -23170)
   - sym 10 -> (-23170, +23170)
   - sym 11 -> (-23170, -23170)
